trx_sched: RTL and testbench
============================

Name: trx_sched

Overview:
Half-duplex TX/RX scheduler for the modem's shared DDS, DUC and DDC/LPF chain.
- Grants the channel to either the modulator (TX) or the demodulator (RX), never both.
- Ramps the TX amplitude scale up and down around each burst.
- Gates ADC-valid into the DDC and masks the LPF output while the FIR pipeline drains.
- Enforces a guard interval at every direction change. Sits between the modem control logic and the DUC/DDC top.

Parameters:
RAMP_LEN, 16, cycles per amplitude ramp; power of two, 2..1024.
GUARD_CYC, 32, idle cycles inserted between TX and RX in either direction; at least 1.
FIR_LAT, 18, LPF pipeline latency in clocks; the IQ output is kept unmasked this long after the ADC gate closes.

Ports:
clk  in  1  system clock (single domain).
rstn  in  1  asynchronous active-low reset.
tx_req  in  1  level; modulator wants the channel. Held high until tx_grant or until it gives up.
tx_done  in  1  one-cycle pulse; last TX sample has been issued.
rx_en  in  1  level; demodulator wants to listen.
tx_grant  out  1  high only in TX_ON; modulator may drive I/Q.
duc_gain  out  16  unsigned Q1.15 scale applied to I/Q ahead of the DUC.
adc_gate  out  1  ANDed with adc_val into the DDC.
iq_mask  out  1  ANDed with the LPF IQ_val toward the demodulator.
busy  out  1  high in every state except IDLE and RX.
state_o  out  3  current state encoding, for debug.

Behaviour:
Reset (asynchronous assert, synchronous release):
- All outputs 0; state IDLE; counters 0.

Registering and latency:
- All outputs are registered.
- A state transition is visible on the outputs in the cycle after the decision.

States and transitions (encoding in parentheses):
- IDLE (0): gain 0, adc_gate 0, iq_mask 0.
  - tx_req has priority over rx_en: tx_req → GUARD_TX.
  - Otherwise rx_en → RX.
- RX (1): adc_gate 1, iq_mask 1.
  - tx_req → RX_DRAIN.
  - rx_en low with no tx_req → RX_DRAIN, which then exits to IDLE.
- RX_DRAIN (2): adc_gate 0, iq_mask stays 1 for exactly FIR_LAT cycles, then 0.
  - Exit to GUARD_TX if tx_req is high at drain end; otherwise to IDLE.
- GUARD_TX (3): everything 0 for GUARD_CYC cycles.
  - Then → RAMP_UP if tx_req is still high; otherwise → IDLE.
- RAMP_UP (4): gain += 32768/RAMP_LEN each cycle starting from 0, saturating at 0x7FFF.
  - After RAMP_LEN cycles → TX_ON.
  - tx_req dropping mid-ramp → RAMP_DN, starting from the current gain.
- TX_ON (5): gain 0x7FFF, tx_grant 1.
  - tx_done → RAMP_DN.
  - tx_req low also → RAMP_DN (abort).
- RAMP_DN (6): gain -= step each cycle, floor 0.
  - On reaching 0 → GUARD_RX.
- GUARD_RX (7): everything 0 for GUARD_CYC cycles.
  - Then → RX if rx_en; otherwise IDLE.
  - A tx_req arriving here goes to RAMP_UP directly after the guard (guard already satisfied).

Gain arithmetic:
- 17-bit internal accumulation, clamped to 0..0x7FFF.
- The ramp never overshoots and never wraps.

Boundary rules:
- tx_done outside TX_ON is ignored.
- tx_done and tx_req falling in the same cycle is a single RAMP_DN entry.
- rx_en changes outside IDLE/RX/GUARD_RX are sampled only at those decision points.
- Counters reload on every state entry.
- Reset mid-ramp forces gain 0 asynchronously.

Optional Feature:
TRX_SCHED_TIMEOUT_EN:
- Defined:
  - Adds a parameter TX_MAX_CYC (default 65536) and an output tx_timeout (1 bit, sticky).
  - If TX_ON lasts TX_MAX_CYC cycles without tx_done, tx_timeout is set and the FSM forces RAMP_DN.
  - tx_timeout clears only on reset or on the next tx_grant rise.
- Undefined: no watchdog and no tx_timeout port; TX_ON holds until tx_done or tx_req falls.

Test Plan:
1. Reset, then rx_en=1 → adc_gate=1 and iq_mask=1 on the second clock after reset release; duc_gain=0, busy=0.
2. In RX, pulse tx_req high (held) with defaults:
   - adc_gate falls the next cycle; iq_mask falls 18 cycles later.
   - Then 32 guard cycles, after which gain steps 2048, 4096, …, 30720, 0x7FFF.
   - tx_grant rises after the 16-cycle ramp.
3. In TX_ON, pulse tx_done:
   - tx_grant falls next cycle; gain steps down from 0x7FFF by 2048 to 0 (floor, no wrap).
   - 32 guard cycles, then RX with adc_gate=1 while rx_en=1.
4. tx_req and rx_en both rising in the same cycle in IDLE → GUARD_TX is taken; adc_gate never pulses.
5. Drop tx_req at ramp cycle 5 (gain 10240) → immediate down-ramp 8192, 6144, …, 0; tx_grant never asserts; FSM ends in IDLE.
6. With TRX_SCHED_TIMEOUT_EN defined and TX_MAX_CYC=100, hold TX_ON with no tx_done → at cycle 100 tx_timeout=1 and ramp-down starts. Deassert rstn mid-ramp → all outputs 0 immediately.

Source files
------------

// File: rtl/trx_sched_if.sv
// Control/status bundle between the modem controller and the TX/RX scheduler.
// Carries tx_timeout only when TRX_SCHED_TIMEOUT_EN is defined.
interface trx_sched_if;
  logic        tx_req;
  logic        tx_done;
  logic        rx_en;
  logic        tx_grant;
  logic [15:0] duc_gain;
  logic        adc_gate;
  logic        iq_mask;
  logic        busy;
  logic [2:0]  state_o;
`ifdef TRX_SCHED_TIMEOUT_EN
  logic        tx_timeout;
`endif

  modport master (
    output tx_req, tx_done, rx_en,
`ifdef TRX_SCHED_TIMEOUT_EN
    input  tx_timeout,
`endif
    input  tx_grant, duc_gain, adc_gate, iq_mask, busy, state_o
  );

  modport slave (
    input  tx_req, tx_done, rx_en,
`ifdef TRX_SCHED_TIMEOUT_EN
    output tx_timeout,
`endif
    output tx_grant, duc_gain, adc_gate, iq_mask, busy, state_o
  );
endinterface

// File: rtl/trx_sched.sv
// Half-duplex TX/RX scheduler for the shared DDS/DUC/DDC chain: grant, gain ramps, ADC gate, LPF mask.
// Define TRX_SCHED_TIMEOUT_EN to add the TX_ON watchdog (parameter TX_MAX_CYC, sticky tx_timeout).
module trx_sched #(
  parameter int RAMP_LEN   = 16,
  parameter int GUARD_CYC  = 32,
`ifdef TRX_SCHED_TIMEOUT_EN
  parameter int TX_MAX_CYC = 65536,
`endif
  parameter int FIR_LAT    = 18
) (
  input  logic       clk,
  input  logic       rstn,
  trx_sched_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RX    = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_GTX   = 3'd3;
  localparam logic [2:0] S_UP    = 3'd4;
  localparam logic [2:0] S_ON    = 3'd5;
  localparam logic [2:0] S_DN    = 3'd6;
  localparam logic [2:0] S_GRX   = 3'd7;

  localparam int M1 = (FIR_LAT > GUARD_CYC) ? FIR_LAT : GUARD_CYC;
  localparam int M2 = (M1 > RAMP_LEN) ? M1 : RAMP_LEN;
`ifdef TRX_SCHED_TIMEOUT_EN
  localparam int CNT_MAX = (M2 > TX_MAX_CYC) ? M2 : TX_MAX_CYC;
`else
  localparam int CNT_MAX = M2;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(FIR_LAT - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] RAMP_LAST  = CNT_W'(RAMP_LEN - 1);

  localparam logic signed [16:0] STEP   = 17'(32768 / RAMP_LEN);
  localparam logic        [15:0] STEP_U = 16'(32768 / RAMP_LEN);
  localparam logic signed [16:0] GMAX   = 17'sh07FFF;

  logic [2:0]       state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      gain, gain_nxt;
  logic             grant, gate, mask, busy_r;
  logic             tmo_hit;

  // 17-bit signed accumulation keeps the ramp from overshooting 0x7FFF or wrapping below 0
  function automatic logic [15:0] gain_up(input logic [15:0] g);
    logic signed [16:0] s;
    s = $signed({1'b0, g}) + STEP;
    return (s > GMAX) ? 16'h7FFF : s[15:0];
  endfunction

  function automatic logic [15:0] gain_dn(input logic [15:0] g);
    logic signed [16:0] s;
    s = $signed({1'b0, g}) - STEP;
    return s[16] ? 16'h0000 : s[15:0];
  endfunction

`ifdef TRX_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TX_MAX_CYC - 1);
  logic tmo;
  assign tmo_hit        = (state == S_ON) && (cnt == TMO_LAST);
  assign bus.tx_timeout = tmo;
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    nxt      = state;
    gain_nxt = gain;
    case (state)
      S_IDLE: begin
        if (bus.tx_req)     nxt = S_GTX;
        else if (bus.rx_en) nxt = S_RX;
      end
      S_RX:    if (bus.tx_req || !bus.rx_en) nxt = S_DRAIN;
      S_DRAIN: if (cnt == DRAIN_LAST) nxt = bus.tx_req ? S_GTX : S_IDLE;
      S_GTX: begin
        if (cnt == GUARD_LAST) begin
          if (bus.tx_req) begin
            nxt      = S_UP;
            gain_nxt = STEP_U;
          end else begin
            nxt = S_IDLE;
          end
        end
      end
      S_UP: begin
        if (!bus.tx_req) begin
          gain_nxt = gain_dn(gain);
          nxt      = (gain_nxt == 16'd0) ? S_GRX : S_DN;
        end else if (cnt == RAMP_LAST) begin
          nxt      = S_ON;
          gain_nxt = 16'h7FFF;
        end else begin
          gain_nxt = gain_up(gain);
        end
      end
      S_ON: begin
        if (bus.tx_done || !bus.tx_req || tmo_hit) begin
          gain_nxt = gain_dn(gain);
          nxt      = S_DN;
        end
      end
      S_DN: begin
        gain_nxt = gain_dn(gain);
        if (gain_nxt == 16'd0) nxt = S_GRX;
      end
      S_GRX: begin
        // the guard just served also satisfies a new TX request, so skip GUARD_TX
        if (cnt == GUARD_LAST) begin
          if (bus.tx_req) begin
            nxt      = S_UP;
            gain_nxt = STEP_U;
          end else if (bus.rx_en) begin
            nxt = S_RX;
          end else begin
            nxt = S_IDLE;
          end
        end
      end
      default: begin
        nxt      = S_IDLE;
        gain_nxt = '0;
      end
    endcase
  end

  // Outputs decode the next state so every output is a flop aligned with state_o
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      cnt    <= '0;
      gain   <= '0;
      grant  <= 1'b0;
      gate   <= 1'b0;
      mask   <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      state  <= nxt;
      cnt    <= (nxt != state) ? '0 : cnt + 1'b1;
      gain   <= gain_nxt;
      grant  <= (nxt == S_ON);
      gate   <= (nxt == S_RX);
      mask   <= (nxt == S_RX) || (nxt == S_DRAIN);
      busy_r <= !((nxt == S_IDLE) || (nxt == S_RX));
    end
  end

`ifdef TRX_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                            tmo <= 1'b0;
    else if (nxt == S_ON && state != S_ON) tmo <= 1'b0;
    else if (tmo_hit && !bus.tx_done)      tmo <= 1'b1;
  end
`endif

  assign bus.tx_grant = grant;
  assign bus.duc_gain = gain;
  assign bus.adc_gate = gate;
  assign bus.iq_mask  = mask;
  assign bus.busy     = busy_r;
  assign bus.state_o  = state;
endmodule

// File: tb/tb_trx_sched.sv
// Randomized bench for trx_sched: phase-level reference model checked every cycle, plus directed literal checks.
module tb_trx_sched;
  localparam int RAMP_LEN  = 16;
  localparam int GUARD_CYC = 32;
  localparam int FIR_LAT   = 18;
  localparam int STEP      = 32768 / RAMP_LEN;
`ifdef TRX_SCHED_TIMEOUT_EN
  localparam bit TMO    = 1'b1;
  localparam int TX_MAX = 100;
`else
  localparam bit TMO    = 1'b0;
  localparam int TX_MAX = 0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad   = 0;

  trx_sched_if bus();

`ifdef TRX_SCHED_TIMEOUT_EN
  trx_sched #(.RAMP_LEN(RAMP_LEN), .GUARD_CYC(GUARD_CYC), .TX_MAX_CYC(TX_MAX), .FIR_LAT(FIR_LAT))
    dut (.clk(clk), .rstn(rstn), .bus(bus));
`else
  trx_sched #(.RAMP_LEN(RAMP_LEN), .GUARD_CYC(GUARD_CYC), .FIR_LAT(FIR_LAT))
    dut (.clk(clk), .rstn(rstn), .bus(bus));
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which phase the channel is in, cycles left in timed phases, gain as plain integer
  typedef enum int {P_IDLE = 0, P_RX = 1, P_DRAIN = 2, P_GTX = 3,
                    P_UP = 4, P_ON = 5, P_DN = 6, P_GRX = 7} ph_t;
  ph_t ph   = P_IDLE;
  int  left = 0;
  int  g    = 0;
  int  ton  = 0;
  bit  tmo  = 1'b0;

  function automatic void enter(input ph_t p);
    ph = p;
    case (p)
      P_DRAIN:      left = FIR_LAT;
      P_GTX, P_GRX: left = GUARD_CYC;
      P_UP:         left = RAMP_LEN;
      default:      left = 0;
    endcase
    if (p == P_UP)       g = STEP;
    else if (p == P_ON)  g = 32767;
    else if (p != P_DN)  g = 0;
    if (p == P_ON) begin
      ton = 0;
      tmo = 1'b0;
    end
  endfunction

  function automatic void ramp_down();
    g = g - STEP;
    if (g <= 0) enter(P_GRX);
    else        ph = P_DN;
  endfunction

  function automatic void model_step(input bit tr, input bit td, input bit re);
    case (ph)
      P_IDLE: if (tr) enter(P_GTX); else if (re) enter(P_RX);
      P_RX:   if (tr || !re) enter(P_DRAIN);
      P_DRAIN: begin
        left = left - 1;
        if (left == 0) enter(tr ? P_GTX : P_IDLE);
      end
      P_GTX: begin
        left = left - 1;
        if (left == 0) enter(tr ? P_UP : P_IDLE);
      end
      P_UP: begin
        if (!tr) ramp_down();
        else begin
          left = left - 1;
          if (left == 0) enter(P_ON);
          else g = (g + STEP > 32767) ? 32767 : g + STEP;
        end
      end
      P_ON: begin
        ton = ton + 1;
        if (td || !tr || (TMO && ton == TX_MAX)) begin
          if (TMO && ton == TX_MAX && !td) tmo = 1'b1;
          ramp_down();
        end
      end
      P_DN: ramp_down();
      P_GRX: begin
        left = left - 1;
        if (left == 0) begin
          if (tr)      enter(P_UP);
          else if (re) enter(P_RX);
          else         enter(P_IDLE);
        end
      end
      default: enter(P_IDLE);
    endcase
  endfunction

  // Inputs change just after posedge, so at negedge they hold what the next edge will sample
  always @(negedge clk) begin
    if (!rstn) begin
      ph = P_IDLE; left = 0; g = 0; ton = 0; tmo = 1'b0;
    end else begin
      check("m_state", int'(bus.state_o), int'(ph));
      check("m_gain",  int'(bus.duc_gain), g);
      check("m_grant", int'(bus.tx_grant), int'(ph == P_ON));
      check("m_gate",  int'(bus.adc_gate), int'(ph == P_RX));
      check("m_mask",  int'(bus.iq_mask), int'(ph == P_RX || ph == P_DRAIN));
      check("m_busy",  int'(bus.busy), int'(!(ph == P_IDLE || ph == P_RX)));
`ifdef TRX_SCHED_TIMEOUT_EN
      check("m_tmo",   int'(bus.tx_timeout), int'(tmo));
`endif
      model_step(bus.tx_req, bus.tx_done, bus.rx_en);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int exp;
    bit seen;
    int p_tr, p_re, p_td;
    bus.tx_req  = 1'b0;
    bus.tx_done = 1'b0;
    bus.rx_en   = 1'b0;
    p_tr = 40; p_re = 50; p_td = 30;

    // reset state, then RX on the second clock after release
    repeat (2) @(posedge clk);
    #1;
    check("rst_gain",  int'(bus.duc_gain), 0);
    check("rst_state", int'(bus.state_o), 0);
    check("rst_busy",  int'(bus.busy), 0);
    check("rst_gate",  int'(bus.adc_gate), 0);
    rstn = 1'b1;
    tick();
    bus.rx_en = 1'b1;
    tick();
    check("t1_gate", int'(bus.adc_gate), 1);
    check("t1_mask", int'(bus.iq_mask), 1);
    check("t1_gain", int'(bus.duc_gain), 0);
    check("t1_busy", int'(bus.busy), 0);

    // RX -> drain -> guard -> ramp up -> TX_ON
    repeat (3) tick();
    bus.tx_req = 1'b1;
    tick();
    check("t2_gate_off", int'(bus.adc_gate), 0);
    check("t2_drain",    int'(bus.state_o), 2);
    n = 0;
    for (int i = 0; i < 100 && bus.iq_mask; i++) begin n++; tick(); end
    check("t2_mask_len", n, 18);
    n = 0;
    for (int i = 0; i < 100 && bus.state_o == 3'd3; i++) begin n++; tick(); end
    check("t2_guard_len", n, 32);
    for (int k = 1; k <= 16; k++) begin
      check("t2_ramp_gain", int'(bus.duc_gain), (k * 2048 > 32767) ? 32767 : k * 2048);
      check("t2_ramp_nogrant", int'(bus.tx_grant), 0);
      tick();
    end
    check("t2_grant",  int'(bus.tx_grant), 1);
    check("t2_full",   int'(bus.duc_gain), 32767);

    // tx_done together with tx_req falling: one ramp-down, floor at 0, guard, back to RX
    repeat (4) tick();
    bus.tx_done = 1'b1;
    bus.tx_req  = 1'b0;
    tick();
    bus.tx_done = 1'b0;
    check("t3_grant_off", int'(bus.tx_grant), 0);
    n = 0; exp = 32767;
    for (int i = 0; i < 40 && bus.state_o == 3'd6; i++) begin
      exp -= 2048;
      check("t3_dn_gain", int'(bus.duc_gain), exp);
      n++;
      tick();
    end
    check("t3_dn_len", n, 15);
    check("t3_floor",  int'(bus.duc_gain), 0);
    check("t3_grx",    int'(bus.state_o), 7);
    n = 0;
    for (int i = 0; i < 100 && bus.state_o == 3'd7; i++) begin n++; tick(); end
    check("t3_guard_len", n, 32);
    check("t3_rx_gate",   int'(bus.adc_gate), 1);

    // back to IDLE, then tx_req and rx_en rise together
    bus.rx_en = 1'b0;
    for (int i = 0; i < 100 && bus.state_o != 3'd0; i++) tick();
    check("t4_idle", int'(bus.state_o), 0);
    bus.tx_req = 1'b1;
    bus.rx_en  = 1'b1;
    tick();
    check("t4_gtx", int'(bus.state_o), 3);
    bus.rx_en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && bus.duc_gain != 16'd10240; i++) begin
      if (bus.adc_gate) seen = 1'b1;
      tick();
    end
    check("t4_no_gate", int'(seen), 0);
    check("t5_gain5",   int'(bus.duc_gain), 10240);

    // abort mid-ramp
    bus.tx_req = 1'b0;
    seen = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      tick();
      if (bus.tx_grant) seen = 1'b1;
      check("t5_dn_gain", int'(bus.duc_gain), k * 2048);
    end
    tick();
    check("t5_zero",     int'(bus.duc_gain), 0);
    check("t5_grx",      int'(bus.state_o), 7);
    check("t5_no_grant", int'(seen), 0);
    repeat (32) tick();
    check("t5_idle", int'(bus.state_o), 0);

`ifdef TRX_SCHED_TIMEOUT_EN
    bus.tx_req = 1'b1;
    for (int i = 0; i < 200 && !bus.tx_grant; i++) tick();
    n = 0;
    for (int i = 0; i < 300 && bus.tx_grant; i++) begin n++; tick(); end
    check("t6_on_len",  n, 100);
    check("t6_timeout", int'(bus.tx_timeout), 1);
    check("t6_dn",      int'(bus.state_o), 6);
    bus.tx_req = 1'b0;
`endif

    // randomized traffic against the model
    for (int c = 0; c < 20000; c++) begin
      tick();
      if (c % 500 == 0) begin
        p_tr = int'($urandom_range(8, 120));
        p_re = int'($urandom_range(10, 150));
        p_td = int'($urandom_range(3, 60));
      end
      bus.tx_done = ($urandom_range(1, p_td) == 1);
      if ($urandom_range(1, p_tr) == 1) bus.tx_req = ~bus.tx_req;
      if ($urandom_range(1, p_re) == 1) bus.rx_en  = ~bus.rx_en;
    end

    // asynchronous reset in the middle of a ramp
    bus.tx_req  = 1'b0;
    bus.tx_done = 1'b0;
    bus.rx_en   = 1'b0;
    for (int i = 0; i < 300 && bus.state_o != 3'd0; i++) tick();
    check("t7_idle", int'(bus.state_o), 0);
    bus.tx_req = 1'b1;
    for (int i = 0; i < 100 && !(bus.state_o == 3'd4 && bus.duc_gain >= 16'd4096); i++) tick();
    check("t7_ramping", int'(bus.state_o), 4);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("t7_gain",  int'(bus.duc_gain), 0);
    check("t7_state", int'(bus.state_o), 0);
    check("t7_busy",  int'(bus.busy), 0);
    check("t7_gate",  int'(bus.adc_gate), 0);
    check("t7_mask",  int'(bus.iq_mask), 0);
    check("t7_grant", int'(bus.tx_grant), 0);
`ifdef TRX_SCHED_TIMEOUT_EN
    check("t7_tmo",   int'(bus.tx_timeout), 0);
`endif
    bus.tx_req = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
